// File: rtl/superkekb_pkg.sv
// Shared constants and state encoding for the SuperKEKB revolution-marker receiver.
package superkekb_pkg;

  localparam int QUAD_BUNCHES_PER_REVOLUTION = 1280;
  localparam int REVO_WORD_WIDTH             = 8;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } revo_state_t;

endpackage

// File: rtl/superkekb_revo_edge_finder.sv
// Finds the 0->1 transition in the revo bit stream and reports its bit phase within the word.
module superkekb_revo_edge_finder
  import superkekb_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic [REVO_WORD_WIDTH-1:0] revo_word,
  output logic                       edge_valid,
  output logic [2:0]                 phase,
  output logic                       glitch
);

  // Only the last bit of the previous word can precede an edge, so only it is kept.
  logic                       prev_word_lsb;
  logic [REVO_WORD_WIDTH:0]   bit_stream;
  logic [REVO_WORD_WIDTH-1:0] rising;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) prev_word_lsb <= 1'b1;
    else       prev_word_lsb <= revo_word[0];
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    phase      = '0;
    bit_stream = {prev_word_lsb, revo_word};
    rising     = bit_stream[REVO_WORD_WIDTH-1:0] & ~bit_stream[REVO_WORD_WIDTH:1];
    for (int k = 0; k < REVO_WORD_WIDTH; k++) begin
      if (rising[k]) phase = 3'(REVO_WORD_WIDTH - 1 - k);
    end
    edge_valid = ($countones(rising) == 1);
    glitch     = ($countones(rising) > 1);
  end

endmodule

// File: rtl/superkekb_revo_receiver.sv
// Revolution-marker receiver: hunts for the revo edge, verifies the period, then flywheels
// the quad-bunch index while counting bad revolutions.
module superkekb_revo_receiver
  import superkekb_pkg::*;
#(
  parameter int QUAD_BUNCHES = QUAD_BUNCHES_PER_REVOLUTION,
  parameter int INDEX_WIDTH  = 11,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [REVO_WORD_WIDTH-1:0] revo_word,
  output logic [INDEX_WIDTH-1:0]     quad_bunch_index,
  output logic [2:0]                 bit_phase,
  output logic                       revo_strobe,
  output logic                       locked,
  output logic                       edge_error,
  output logic [15:0]                error_count
);

  localparam int GOOD_WIDTH = $clog2(LOCK_COUNT + 1);
  localparam int BAD_WIDTH  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX    = INDEX_WIDTH'(QUAD_BUNCHES - 1);
  localparam logic [GOOD_WIDTH-1:0]  LOCK_TARGET   = GOOD_WIDTH'(LOCK_COUNT);
  localparam logic [BAD_WIDTH-1:0]   UNLOCK_TARGET = BAD_WIDTH'(UNLOCK_COUNT);

  revo_state_t            state;
  logic [GOOD_WIDTH-1:0]  good_count;
  logic [BAD_WIDTH-1:0]   bad_count;
  logic                   edge_valid;
  logic [2:0]             edge_phase;
  logic                   glitch;

  logic                   expected;
  logic                   match;
  logic                   missing;
  logic                   misplaced;
  logic [GOOD_WIDTH-1:0]  good_next;
  logic [BAD_WIDTH-1:0]   bad_next;
  logic [INDEX_WIDTH-1:0] index_next;

  superkekb_revo_edge_finder u_edge_finder (
    .clock      (clock),
    .reset      (reset),
    .revo_word  (revo_word),
    .edge_valid (edge_valid),
    .phase      (edge_phase),
    .glitch     (glitch)
  );

  // A glitch word has edge_valid low, so on the expected word it falls into 'missing'.
  always_comb begin
    expected   = (quad_bunch_index == LAST_INDEX);
    match      = expected && edge_valid && (edge_phase == bit_phase);
    missing    = expected && !edge_valid;
    misplaced  = edge_valid && !match;
    good_next  = good_count + GOOD_WIDTH'(1);
    bad_next   = bad_count + BAD_WIDTH'(1);
    index_next = expected ? '0 : quad_bunch_index + INDEX_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= HUNT;
      quad_bunch_index <= '0;
      bit_phase        <= '0;
      revo_strobe      <= 1'b0;
      locked           <= 1'b0;
      edge_error       <= 1'b0;
      error_count      <= '0;
      good_count       <= '0;
      bad_count        <= '0;
    end else begin
      edge_error  <= glitch;
      revo_strobe <= 1'b0;
      case (state)
        HUNT: begin
          quad_bunch_index <= '0;
          if (edge_valid) begin
            state       <= VERIFY;
            bit_phase   <= edge_phase;
            good_count  <= '0;
            revo_strobe <= 1'b1;
          end
        end

        VERIFY: begin
          if (match) begin
            quad_bunch_index <= '0;
            revo_strobe      <= 1'b1;
            good_count       <= good_next;
            if (good_next == LOCK_TARGET) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              bad_count <= '0;
            end
          end else if (missing) begin
            state            <= HUNT;
            quad_bunch_index <= '0;
          end else if (misplaced) begin
            // Unexpected edge or wrong phase: reseed the period from this word.
            quad_bunch_index <= '0;
            bit_phase        <= edge_phase;
            good_count       <= '0;
            revo_strobe      <= 1'b1;
          end else begin
            quad_bunch_index <= index_next;
          end
        end

        LOCKED: begin
          // Flywheel: the index only follows its own period, never the incoming edges.
          quad_bunch_index <= index_next;
          revo_strobe      <= expected;
          if (match) begin
            bad_count <= '0;
          end else if (missing || misplaced) begin
            bad_count <= bad_next;
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            if (bad_next == UNLOCK_TARGET) begin
              state            <= HUNT;
              locked           <= 1'b0;
              quad_bunch_index <= '0;
              revo_strobe      <= 1'b0;
            end
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: doc/superkekb_revo_receiver.md
# superkekb_revo_receiver

Recovers the SuperKEKB revolution marker from a deserialized 8-bit revo word stream, one word per quad-bunch clock, MSB first in time. It locates the rising edge with sub-word bit phase and verifies the 1280-word revolution period. It then flywheels a quad-bunch index and reports lock state and error counts to downstream timing and trigger logic. It is the receive end of the revo word generator: 640 words of 8'h00 followed by 640 words of 8'hFF per revolution.

## Interface
- QUAD_BUNCHES, 1280: words per revolution.
- INDEX_WIDTH, 11: width of the quad-bunch index; must satisfy 2**INDEX_WIDTH >= QUAD_BUNCHES.
- LOCK_COUNT, 4: consecutive good revolutions in VERIFY needed to reach LOCKED.
- UNLOCK_COUNT, 2: consecutive bad revolutions in LOCKED that force a return to HUNT.
- clock  in  1  quad-bunch word clock.
- reset  in  1  synchronous, active-high.
- revo_word  in  8  deserialized revo word; bit 7 is the earliest in time.
- quad_bunch_index  out  INDEX_WIDTH  position in the revolution; 0 on the edge word.
- bit_phase  out  3  captured fine phase: number of 0 bits preceding the rising edge within the edge word.
- revo_strobe  out  1  one-cycle pulse when the index is 0 and the state is VERIFY or LOCKED.
- locked  out  1  high in state LOCKED.
- edge_error  out  1  one-cycle pulse on a glitch word.
- error_count  out  16  saturating count of bad revolutions while LOCKED.

## Operation
- Edge find: form the 9-bit sequence {prev_word[0], revo_word}. A rising edge exists at bit k if revo_word[k]=1 and the preceding bit is 0. The preceding bit is revo_word[k+1], or prev_word[0] when k=7.
  - Exactly one rising edge: edge valid, phase = 7-k.
  - More than one rising edge: glitch. Pulse edge_error and treat the word as having no edge.
  - prev_word resets to 8'hFF.
- Period counter: counts 0..QUAD_BUNCHES-1 and wraps to 0. A word is "expected" when the counter is about to wrap, i.e. the word arrives with the counter at QUAD_BUNCHES-1.
- Match: valid edge on the expected word with phase equal to the captured phase.
- Mismatch: any of the following:
  - no valid edge on the expected word;
  - a valid edge on an unexpected word;
  - a valid edge on the expected word with a phase that differs from the captured phase.
- State HUNT: the counter is held at 0. On a valid edge, capture the phase, set counter to 0, clear good_count, and go to VERIFY.
- State VERIFY:
  - Match: good_count+1. When good_count reaches LOCK_COUNT, go to LOCKED with bad_count cleared.
  - Missing edge: go to HUNT.
  - Unexpected edge or wrong phase: reseed from that word. Counter goes to 0, phase is recaptured, good_count is cleared, and the state stays VERIFY.
- State LOCKED: the counter free-runs (flywheel). Edges never realign it.
  - Match: clear bad_count.
  - Mismatch: bad_count+1 and error_count+1, saturating at 16'hFFFF. At most one mismatch is counted per word. When bad_count reaches UNLOCK_COUNT, go to HUNT.
  - Leaving LOCKED does not clear error_count. Only reset clears it.
- Simultaneous events: a glitch on the expected word is a missing edge. A match and a mismatch cannot occur on the same word.

## Timing
- All outputs are registered. The word sampled at edge n is reflected in the outputs after edge n+1 (latency 1).
- revo_strobe is asserted for exactly one cycle, coincident with quad_bunch_index = 0.
- locked rises together with the strobe of the LOCK_COUNT-th matched edge after the seeding edge.
- locked falls together with the index-0 cycle of the UNLOCK_COUNT-th consecutive bad revolution, or in the cycle after an unexpected edge that triggers the unlock.
- Reset values:
  - state HUNT;
  - quad_bunch_index 0, bit_phase 0;
  - revo_strobe 0, locked 0, edge_error 0;
  - error_count 0, good_count 0, bad_count 0.
- Reset in mid-operation takes effect on the next edge and overrides all other events.

## Structure
- Package superkekb_pkg holds:
  - QUAD_BUNCHES_PER_REVOLUTION = 1280 and REVO_WORD_WIDTH = 8;
  - the state enum typedef {HUNT, VERIFY, LOCKED}.
- Sub-module superkekb_revo_edge_finder contains the prev_word register and the edge/phase/glitch decode. Its outputs are edge_valid, phase[2:0] and glitch.
- The top level holds the state machine, the counters, and the output registers.

## Test plan
- Clean stream, 640×8'h00 then 640×8'hFF, repeated: locked=1 after the fifth edge; revo_strobe every 1280 cycles; index 0 and bit_phase 0 at each strobe.
- Edge word 8'b00011111 with neighbours 8'h00 before and 8'hFF after: bit_phase=3; lock achieved as in the clean case.
- While locked, replace one edge word with 8'h00 (held low): error_count=1, locked stays 1. Two consecutive missing edges: locked=0 and state HUNT; error_count=2.
- During VERIFY, shorten one revolution to 1279 words: reseed; locked is not asserted until LOCK_COUNT further good revolutions.
- Word 8'b01010000 anywhere: edge_error pulses for one cycle and index alignment is unchanged. On the expected word it counts as a missing edge.
- Assert reset while locked with error_count=5: after the next edge, every output is at its reset value; relock follows the clean-case timing.
